jk_tff_counter: RTL and testbench

- Parametrised synchronous up/down counter whose state bits are JK cells wired as toggle (T) flip-flops.
- Per-bit T is derived from the current state and the direction: T[i] = q[i] XOR next[i].
- Adds programmable modulus, wrap or saturate mode, parallel load, synchronous clear, a wrap-event pulse and a sticky overflow flag.
- Used as the general event/timebase counter for the flip-flop-based datapaths in the design.

---
 rtl/jk_tff_counter.sv | 167 ++++++++++++++++
 tb/tb_jk_tff_counter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/jk_tff_counter.sv
// rtl/jk_tff_counter.sv - up/down modulus counter built from JK cells wired as T flip-flops
// Optional prescaler: define JK_TFF_CNT_PRESCALE_EN.

module jk_tff_cell (
    input  logic clk_i,
    input  logic rst_i,
    input  logic j_i,
    input  logic k_i,
    output logic q_o
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = (j_i & ~q_q) | (~k_i & q_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

module jk_tff_counter #(
    parameter int             WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
    parameter int             SATURATE = 0,
    parameter int             PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             ovf
);

    if (WIDTH < 1 || WIDTH > 32 || PRESCALE < 2) begin : g_bad_params
        $error("jk_tff_counter: WIDTH must be 1..32 and PRESCALE at least 2");
    end

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] next_step;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] t_vec;
    logic             at_max;
    logic             at_zero;
    logic             boundary;
    logic             presc_hit;
    logic             step;
    logic             wrap_q;
    logic             wrap_d;
    logic             ovf_q;
    logic             ovf_d;

`ifdef JK_TFF_CNT_PRESCALE_EN
    localparam int PW = $clog2(PRESCALE);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;

    assign presc_hit = (presc_q == PW'(PRESCALE - 1));

    always_comb begin
        presc_d = presc_q;
        if (clr || load) begin
            presc_d = '0;
        end else if (en) begin
            presc_d = presc_hit ? '0 : presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    assign presc_hit = 1'b1;
`endif

    assign at_max   = (cnt_q == MAX_VAL);
    assign at_zero  = (cnt_q == '0);
    assign boundary = up_dn ? at_max : at_zero;
    assign step     = en & ~clr & ~load & presc_hit;

    always_comb begin
        next_step = cnt_q;
        if (up_dn) begin
            if (at_max) begin
                next_step = (SATURATE != 0) ? MAX_VAL : '0;
            end else begin
                next_step = cnt_q + WIDTH'(1);
            end
        end else begin
            if (at_zero) begin
                next_step = (SATURATE != 0) ? '0 : MAX_VAL;
            end else begin
                next_step = cnt_q - WIDTH'(1);
            end
        end
    end

    assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

    always_comb begin
        target = cnt_q;
        if (clr) begin
            target = '0;
        end else if (load) begin
            target = load_clamped;
        end else if (step) begin
            target = next_step;
        end
    end

    // Every state change, including clear and load, goes through the toggle inputs.
    assign t_vec = cnt_q ^ target;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_tff_cell u_cell (
            .clk_i (clk),
            .rst_i (reset),
            .j_i   (t_vec[i]),
            .k_i   (t_vec[i]),
            .q_o   (cnt_q[i])
        );
    end

    always_comb begin
        wrap_d = step & boundary;
        ovf_d  = ovf_q | (step & boundary);
        if (clr) begin
            wrap_d = 1'b0;
            ovf_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign q    = cnt_q;
    assign wrap = wrap_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_jk_tff_counter.sv
// tb/tb_jk_tff_counter.sv - scoreboard bench for jk_tff_counter

module tb_jk_tff_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       en_a, up_a, ld_a, clr_a;
    logic [3:0] lv_a, q_a;
    logic       wrap_a, ovf_a;
    logic       en_b, up_b, ld_b, clr_b;
    logic [3:0] lv_b, q_b;
    logic       wrap_b, ovf_b;
    logic       en_c, up_c, ld_c, clr_c;
    logic [7:0] lv_c, q_c;
    logic       wrap_c, ovf_c;

    jk_tff_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(0), .PRESCALE(4)) u_a (
        .clk(clk), .reset(reset), .en(en_a), .up_dn(up_a), .load(ld_a), .load_val(lv_a),
        .clr(clr_a), .q(q_a), .wrap(wrap_a), .ovf(ovf_a));

    jk_tff_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1), .PRESCALE(4)) u_b (
        .clk(clk), .reset(reset), .en(en_b), .up_dn(up_b), .load(ld_b), .load_val(lv_b),
        .clr(clr_b), .q(q_b), .wrap(wrap_b), .ovf(ovf_b));

    jk_tff_counter #(.WIDTH(8), .MAX_VAL(8'hFF), .SATURATE(0), .PRESCALE(4)) u_c (
        .clk(clk), .reset(reset), .en(en_c), .up_dn(up_c), .load(ld_c), .load_val(lv_c),
        .clr(clr_c), .q(q_c), .wrap(wrap_c), .ovf(ovf_c));

    typedef struct {
        int         dut;
        logic [7:0] q;
        logic       wrap;
        logic       ovf;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] aq;
        logic       aw;
        logic       ao;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.dut)
                0:       begin aq = {4'h0, q_a}; aw = wrap_a; ao = ovf_a; end
                1:       begin aq = {4'h0, q_b}; aw = wrap_b; ao = ovf_b; end
                default: begin aq = q_c;         aw = wrap_c; ao = ovf_c; end
            endcase
            chk($sformatf("%s_d%0d_q", e.tag, e.dut), aq, e.q);
            chk($sformatf("%s_d%0d_wrap", e.tag, e.dut), {7'h0, aw}, {7'h0, e.wrap});
            chk($sformatf("%s_d%0d_ovf", e.tag, e.dut), {7'h0, ao}, {7'h0, e.ovf});
        end
    end

    task automatic idle_all();
        en_a = 1'b0; up_a = 1'b1; ld_a = 1'b0; clr_a = 1'b0; lv_a = 4'h0;
        en_b = 1'b0; up_b = 1'b1; ld_b = 1'b0; clr_b = 1'b0; lv_b = 4'h0;
        en_c = 1'b0; up_c = 1'b1; ld_c = 1'b0; clr_c = 1'b0; lv_c = 8'h0;
    endtask

    task automatic expect_now(input int d, input logic [7:0] eq, input logic ew,
                              input logic eo, input string tag);
        exp_t x;
        x.dut = d; x.q = eq; x.wrap = ew; x.ovf = eo; x.tag = tag;
        sb.push_back(x);
    endtask

    // Drive one DUT for one clock edge, then queue what it must show after that edge.
    task automatic step(input int d, input logic e, input logic u, input logic l,
                        input logic [7:0] lv, input logic c,
                        input logic [7:0] eq, input logic ew, input logic eo,
                        input string tag);
        idle_all();
        case (d)
            0:       begin en_a = e; up_a = u; ld_a = l; lv_a = lv[3:0]; clr_a = c; end
            1:       begin en_b = e; up_b = u; ld_b = l; lv_b = lv[3:0]; clr_b = c; end
            default: begin en_c = e; up_c = u; ld_c = l; lv_c = lv;      clr_c = c; end
        endcase
        @(posedge clk);
        expect_now(d, eq, ew, eo, tag);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        idle_all();
        @(posedge clk);
        #2;
        expect_now(0, 8'h0, 1'b0, 1'b0, "rst");
        expect_now(1, 8'h0, 1'b0, 1'b0, "rst");
        expect_now(2, 8'h0, 1'b0, 1'b0, "rst");
        @(negedge clk);
        reset = 1'b0;

`ifdef JK_TFF_CNT_PRESCALE_EN
        for (int k = 1; k <= 12; k++) begin
            step(2, 1, 1, 0, 8'h0, 0, 8'(k / 4), 1'b0, 1'b0, "t6_presc");
            if (k == 5) begin
                step(2, 0, 1, 0, 8'h0, 0, 8'h1, 1'b0, 1'b0, "t6_freeze");
                step(2, 0, 1, 0, 8'h0, 0, 8'h1, 1'b0, 1'b0, "t6_freeze");
            end
        end
`else
        // mod-10 wrap counting up
        for (int i = 1; i <= 12; i++) begin
            step(0, 1, 1, 0, 8'h0, 0, 8'(i % 10), (i == 10), (i >= 10), "t1_up");
        end

        // load beats en, down through zero, clamped load, hold, direction flip
        step(0, 1, 1, 1, 8'd3,  0, 8'd3, 1'b0, 1'b1, "t2_load");
        step(0, 1, 0, 0, 8'h0,  0, 8'd2, 1'b0, 1'b1, "t2_dn");
        step(0, 1, 0, 0, 8'h0,  0, 8'd1, 1'b0, 1'b1, "t2_dn");
        step(0, 1, 0, 0, 8'h0,  0, 8'd0, 1'b0, 1'b1, "t2_dn");
        step(0, 1, 0, 0, 8'h0,  0, 8'd9, 1'b1, 1'b1, "t2_dn_wrap");
        step(0, 1, 0, 0, 8'h0,  0, 8'd8, 1'b0, 1'b1, "t2_dn");
        step(0, 0, 1, 1, 8'd14, 0, 8'd9, 1'b0, 1'b1, "t2_clamp");
        step(0, 0, 1, 0, 8'h0,  0, 8'd9, 1'b0, 1'b1, "t2_hold");
        step(0, 1, 1, 0, 8'h0,  0, 8'd0, 1'b1, 1'b1, "t2_up_wrap");

        // saturate mode
        step(1, 0, 1, 1, 8'd8, 0, 8'd8, 1'b0, 1'b0, "t3_load");
        step(1, 1, 1, 0, 8'h0, 0, 8'd9, 1'b0, 1'b0, "t3_up");
        step(1, 1, 1, 0, 8'h0, 0, 8'd9, 1'b1, 1'b1, "t3_sat");
        step(1, 1, 1, 0, 8'h0, 0, 8'd9, 1'b1, 1'b1, "t3_sat");
        step(1, 1, 0, 0, 8'h0, 0, 8'd8, 1'b0, 1'b1, "t3_dn");
        step(1, 0, 0, 1, 8'd0, 0, 8'd0, 1'b0, 1'b1, "t3_load0");
        step(1, 1, 0, 0, 8'h0, 0, 8'd0, 1'b1, 1'b1, "t3_sat0");
        step(1, 1, 1, 0, 8'h0, 0, 8'd1, 1'b0, 1'b1, "t3_up");

        // full-range 8-bit: all cells toggle, clear priority
        step(2, 0, 1, 1, 8'h7F, 0, 8'h7F, 1'b0, 1'b0, "t4_load");
        step(2, 1, 1, 0, 8'h00, 0, 8'h80, 1'b0, 1'b0, "t4_up");
        step(2, 1, 0, 0, 8'h00, 0, 8'h7F, 1'b0, 1'b0, "t4_dn");
        step(2, 1, 1, 1, 8'hAA, 1, 8'h00, 1'b0, 1'b0, "t4_clr");
        step(2, 1, 0, 0, 8'h00, 0, 8'hFF, 1'b1, 1'b1, "t4_dn_wrap");
        step(2, 0, 0, 0, 8'h00, 0, 8'hFF, 1'b0, 1'b1, "t4_hold");
        step(2, 1, 1, 1, 8'h55, 1, 8'h00, 1'b0, 1'b0, "t4_clr_ovf");

        // asynchronous reset mid-count
        step(0, 0, 1, 1, 8'd0, 0, 8'd0, 1'b0, 1'b1, "t5_load");
        for (int i = 1; i <= 5; i++) begin
            step(0, 1, 1, 0, 8'h0, 0, 8'(i), 1'b0, 1'b1, "t5_up");
        end
        idle_all();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        expect_now(0, 8'h0, 1'b0, 1'b0, "t5_async");
        expect_now(1, 8'h0, 1'b0, 1'b0, "t5_async");
        @(negedge clk);
        reset = 1'b0;
        step(0, 1, 1, 0, 8'h0, 0, 8'd1, 1'b0, 1'b0, "t5_after");
`endif

        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            @(negedge clk);
        end
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
